// File: rtl/regincr_credit_collector_pkg.sv
// Shared helpers for the registered-incrementer credit collector.
// Contents:
//   popcount32 - number of set bits in a 32-bit vector. It counts the
//                in-flight pipeline slots when issue credits are computed.
package regincr_credit_collector_pkg;

    function automatic int popcount32(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/regincr_credit_collector_fifo.sv
// regincr_fifo: circular buffer that holds the captured incrementer results.
// The read and write pointers wrap modulo p_depth. The occupancy count
// ranges from 0 to p_depth.
// Ports:
//   clk, reset        clock, synchronous active-high reset (control state only)
//   enq_en, enq_msg   write enq_msg at the tail this cycle
//   deq_en            pop the head entry this cycle
//   deq_msg           head entry (valid when !empty)
//   count             occupancy
//   full, empty       occupancy flags
module regincr_fifo #(
    parameter int p_nbits = 8,
    parameter int p_depth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enq_en,
    input  logic [p_nbits-1:0]           enq_msg,
    input  logic                         deq_en,
    output logic [p_nbits-1:0]           deq_msg,
    output logic [$clog2(p_depth+1)-1:0] count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CW = $clog2(p_depth+1);

    logic [p_nbits-1:0] mem_q [p_depth];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               enq_fire, deq_fire;

    // Explicit wrap so that a non-power-of-2 depth still indexes correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(p_depth - 1)) return '0;
        return p + PW'(1);
    endfunction

    assign full     = (count_q == CW'(p_depth));
    assign empty    = (count_q == '0);
    assign enq_fire = enq_en && !full;
    assign deq_fire = deq_en && !empty;
    assign deq_msg  = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (deq_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset. Stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (enq_fire) mem_q[wr_ptr_q] <= enq_msg;
    end

endmodule

// File: rtl/regincr_credit_collector.sv
// regincr_credit_collector: sits downstream of a fixed-latency registered
// incrementer that cannot stall. It tracks which incrementer slots carry
// valid data and captures those results into a FIFO. The FIFO drives a
// val/rdy output stream. Issue credits (in_rdy) count both the buffered
// entries and the in-flight entries, so the FIFO can never overflow.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   in_val       upstream drives a valid value into the incrementer
//   in_rdy       upstream may issue this cycle
//   pipe_out     incrementer output
//   out_val      out_msg holds a valid result
//   out_rdy      consumer accepts out_msg this cycle
//   out_msg      oldest captured result
//   out_count    FIFO occupancy
module regincr_credit_collector
    import regincr_credit_collector_pkg::*;
#(
    parameter int p_nbits   = 8,
    parameter int p_latency = 2,
    parameter int p_depth   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_val,
    output logic                         in_rdy,
    input  logic [p_nbits-1:0]           pipe_out,
    output logic                         out_val,
    input  logic                         out_rdy,
    output logic [p_nbits-1:0]           out_msg,
    output logic [$clog2(p_depth+1)-1:0] out_count
);
    localparam int CW = $clog2(p_depth+1);

    logic [p_latency-1:0] vld_q, vld_d;
    logic                 issue, enq, deq;
    logic                 fifo_full, fifo_empty;
    logic [CW-1:0]        count;
    int                   credits_used;

    assign issue = in_val & in_rdy;

    // Valid shift register that mirrors the incrementer pipeline.
    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = issue;
        for (int i = 1; i < p_latency; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) vld_q <= '0;
        else       vld_q <= vld_d;
    end

    // Credits are built from registered state only (plus reset). A slot that
    // a dequeue frees therefore shows up as a credit on the following cycle.
    always_comb begin
        credits_used = int'(count) + popcount32(32'(vld_q));
    end

    assign in_rdy = !reset && !fifo_full && (credits_used < p_depth);

    assign enq = vld_q[p_latency-1];
    assign deq = out_val & out_rdy;

    regincr_fifo #(
        .p_nbits (p_nbits),
        .p_depth (p_depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .enq_en  (enq),
        .enq_msg (pipe_out),
        .deq_en  (deq),
        .deq_msg (out_msg),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_val   = !fifo_empty;
    assign out_count = count;

endmodule

// File: tb/tb_regincr_credit_collector.sv
// Directed bench for regincr_credit_collector. The bench includes a
// two-stage registered incrementer (+1 per stage) upstream of the DUT.
// Inputs are driven on the falling edge. Outputs are checked 1 ns later.
module tb_regincr_credit_collector;

    logic       clk;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_msg;
    logic [7:0] pipe_out;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_msg;
    logic [2:0] out_count;
    logic [7:0] inc_p0, inc_p1;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream two-stage registered incrementer.
    always_ff @(posedge clk) begin
        inc_p0 <= in_msg + 8'd1;
        inc_p1 <= inc_p0 + 8'd1;
    end
    assign pipe_out = inc_p1;

    regincr_credit_collector #(
        .p_nbits   (8),
        .p_latency (2),
        .p_depth   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .pipe_out  (pipe_out),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_msg   (out_msg),
        .out_count (out_count)
    );

    // An enqueue must never hit a full FIFO.
    always @(posedge clk) begin
        if (!reset && dut.u_fifo.enq_en) begin
            total++;
            assert (dut.u_fifo.full === 1'b0)
            else begin
                bad++;
                $error("FAIL overflow: observed full=%0b expected full=0", dut.u_fifo.full);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a new cycle: drive the inputs on the falling edge, then settle.
    task automatic step(input logic rst, input logic v, input logic [7:0] m, input logic r);
        @(negedge clk);
        reset  = rst;
        in_val = v;
        in_msg = m;
        out_rdy = r;
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        in_val  = 1'b0;
        in_msg  = 8'h00;
        out_rdy = 1'b1;

        // 1: reset, then idle
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("post_rst_out_val", 32'(out_val), 32'd0);
        chk("post_rst_count", 32'(out_count), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("idle_out_val", 32'(out_val), 32'd0);

        // 2: single issue of 8'h05, which appears as 8'h07 three cycles later
        step(1'b0, 1'b1, 8'h05, 1'b1);
        chk("s_t0_in_rdy", 32'(in_rdy), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("s_t1_out_val", 32'(out_val), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("s_t2_out_val", 32'(out_val), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("s_t3_out_val", 32'(out_val), 32'd1);
        chk("s_t3_out_msg", 32'(out_msg), 32'h07);
        chk("s_t3_count", 32'(out_count), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("s_t4_out_val", 32'(out_val), 32'd0);
        chk("s_t4_count", 32'(out_count), 32'd0);

        // 3: back-to-back issue of 0..9
        for (int i = 0; i < 14; i++) begin
            step(1'b0, (i < 10), 8'(i), 1'b1);
            chk($sformatf("b2b_in_rdy_%0d", i), 32'(in_rdy), 32'd1);
            if (i >= 3 && i < 13) begin
                chk($sformatf("b2b_val_%0d", i), 32'(out_val), 32'd1);
                chk($sformatf("b2b_msg_%0d", i), 32'(out_msg), 32'(i - 1));
            end else begin
                chk($sformatf("b2b_noval_%0d", i), 32'(out_val), 32'd0);
            end
        end

        // 4: back-pressure fill, then drain
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 8'(8'h10 + k), 1'b0);
            chk($sformatf("fill_in_rdy_%0d", k), 32'(in_rdy), 32'(k < 4));
            chk($sformatf("fill_val_%0d", k), 32'(out_val), 32'(k >= 3));
            chk($sformatf("fill_count_%0d", k), 32'(out_count),
                (k < 3) ? 32'd0 : ((k > 6) ? 32'd4 : 32'(k - 2)));
            if (k >= 3) chk($sformatf("fill_msg_%0d", k), 32'(out_msg), 32'h12);
        end
        for (int d = 0; d < 5; d++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk($sformatf("drain_count_%0d", d), 32'(out_count), 32'(4 - d));
            chk($sformatf("drain_in_rdy_%0d", d), 32'(in_rdy), 32'(d >= 1));
            chk($sformatf("drain_val_%0d", d), 32'(out_val), 32'(d < 4));
            if (d < 4) chk($sformatf("drain_msg_%0d", d), 32'(out_msg), 32'(8'h12 + d));
        end

        // 5: wrap-around of the incrementer
        step(1'b0, 1'b1, 8'hfe, 1'b1);
        step(1'b0, 1'b1, 8'hff, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("wrap_t2_val", 32'(out_val), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("wrap_t3_val", 32'(out_val), 32'd1);
        chk("wrap_t3_msg", 32'(out_msg), 32'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("wrap_t4_val", 32'(out_val), 32'd1);
        chk("wrap_t4_msg", 32'(out_msg), 32'h01);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("wrap_t5_val", 32'(out_val), 32'd0);

        // 6: reset mid-stream with 2 entries buffered and 2 in flight
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 8'(8'h40 + k), 1'b0);
            chk($sformatf("mid_in_rdy_%0d", k), 32'(in_rdy), 32'd1);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("mid_rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("mid_pre_count", 32'(out_count), 32'd2);
        chk("mid_pre_val", 32'(out_val), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("mid_post_val", 32'(out_val), 32'd0);
        chk("mid_post_count", 32'(out_count), 32'd0);
        chk("mid_post_in_rdy", 32'(in_rdy), 32'd1);
        for (int q = 0; q < 5; q++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk($sformatf("mid_stale_val_%0d", q), 32'(out_val), 32'd0);
            chk($sformatf("mid_stale_count_%0d", q), 32'(out_count), 32'd0);
        end

        // normal operation after the mid-stream reset
        step(1'b0, 1'b1, 8'h30, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("again_val", 32'(out_val), 32'd1);
        chk("again_msg", 32'(out_msg), 32'h32);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("again_empty", 32'(out_val), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
